// File: rtl/dac_host.sv
// dac_host: serial transmitter for a 16-bit SPI-style DAC with CS_n framing and an optional LDAC_n commit strobe.
// Optional feature macro DAC_OFFSET_BINARY_EN: invert bit15 on latch (two's complement to offset binary).
`timescale 1ns/1ps
module dac_host #(
  parameter int CLK_DIV  = 1,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1,
  parameter int LDAC_W   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] data,
  input  logic        valid,
  output logic        ready,
  output logic        CS_n,
  output logic        SCLK,
  output logic        DIN,
  output logic        LDAC_n,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    LOAD  = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] LDAC_LAST  = 8'(LDAC_W - 1);

  state_t      state_r, state_s;
  logic [7:0]  phase_r, phase_s;
  logic [4:0]  bit_r, bit_s;
  logic [15:0] shreg_r, shreg_s;
  logic [15:0] word_s;
  logic        cs_n_r, cs_n_s;
  logic        sclk_r, sclk_s;
  logic        din_r, din_s;
  logic        ldac_n_r, ldac_n_s;
  logic        done_r, done_s;
  logic        ready_r, ready_s;

  function automatic logic [15:0] latch_word(input logic [15:0] w);
`ifdef DAC_OFFSET_BINARY_EN
    return {~w[15], w[14:0]};
`else
    return w;
`endif
  endfunction

  assign word_s = latch_word(data);

  // Frame sequencer: next state, counters and next values of every registered output.
  always_comb begin
    state_s  = state_r;
    phase_s  = phase_r + 8'd1;
    bit_s    = bit_r;
    shreg_s  = shreg_r;
    cs_n_s   = cs_n_r;
    sclk_s   = sclk_r;
    din_s    = din_r;
    ldac_n_s = ldac_n_r;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        phase_s = 8'd0;
        if (valid && ready_r) begin
          state_s = SETUP;
          shreg_s = word_s;
          bit_s   = 5'd0;
          cs_n_s  = 1'b0;
          sclk_s  = 1'b0;
          din_s   = word_s[15];
        end else begin
          cs_n_s   = 1'b1;
          sclk_s   = 1'b0;
          ldac_n_s = 1'b1;
        end
      end
      SETUP: begin
        if (phase_r == SETUP_LAST) begin
          state_s = SHIFT;
          phase_s = 8'd0;
        end else begin
          phase_s = phase_r + 8'd1;
        end
      end
      SHIFT: begin
        if (phase_r == DIV_LAST) begin
          phase_s = 8'd0;
          if (!sclk_r) begin
            sclk_s = 1'b1;
          end else if (bit_r == 5'd15) begin
            sclk_s  = 1'b0;
            state_s = HOLD;
          end else begin
            // Rotating keeps the next bit in [14] without shifting zeros into unused positions.
            sclk_s  = 1'b0;
            bit_s   = bit_r + 5'd1;
            shreg_s = {shreg_r[14:0], shreg_r[15]};
            din_s   = shreg_r[14];
          end
        end else begin
          phase_s = phase_r + 8'd1;
        end
      end
      HOLD: begin
        if (phase_r == HOLD_LAST) begin
          phase_s = 8'd0;
          cs_n_s  = 1'b1;
          if (LDAC_W > 0) begin
            state_s  = LOAD;
            ldac_n_s = 1'b0;
          end else begin
            state_s = IDLE;
            done_s  = 1'b1;
          end
        end else begin
          phase_s = phase_r + 8'd1;
        end
      end
      LOAD: begin
        if (phase_r == LDAC_LAST) begin
          phase_s  = 8'd0;
          ldac_n_s = 1'b1;
          state_s  = IDLE;
          done_s   = 1'b1;
        end else begin
          phase_s = phase_r + 8'd1;
        end
      end
      default: begin
        state_s  = IDLE;
        phase_s  = 8'd0;
        cs_n_s   = 1'b1;
        sclk_s   = 1'b0;
        ldac_n_s = 1'b1;
      end
    endcase
    ready_s = (state_s == IDLE) && enable;
  end

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      phase_r  <= 8'd0;
      bit_r    <= 5'd0;
      shreg_r  <= 16'd0;
      cs_n_r   <= 1'b1;
      sclk_r   <= 1'b0;
      din_r    <= 1'b0;
      ldac_n_r <= 1'b1;
      done_r   <= 1'b0;
      ready_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      phase_r  <= phase_s;
      bit_r    <= bit_s;
      shreg_r  <= shreg_s;
      cs_n_r   <= cs_n_s;
      sclk_r   <= sclk_s;
      din_r    <= din_s;
      ldac_n_r <= ldac_n_s;
      done_r   <= done_s;
      ready_r  <= ready_s;
    end
  end

  assign ready  = ready_r;
  assign CS_n   = cs_n_r;
  assign SCLK   = sclk_r;
  assign DIN    = din_r;
  assign LDAC_n = ldac_n_r;
  assign done   = done_r;

endmodule
